// File: rtl/grid_cursor_if.sv
// Button inputs and cursor outputs of grid_cursor_gen.
interface grid_cursor_if #(
    parameter int COLS = 6,
    parameter int ROWS = 4
);
    localparam int XW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int YW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int VW = ((COLS * ROWS) > 1) ? $clog2(COLS * ROWS) : 1;

    logic          restriction;
    logic          dir_up;
    logic          dir_down;
    logic          dir_left;
    logic          dir_right;
    logic [XW-1:0] pos_x;
    logic [YW-1:0] pos_y;
    logic [VW-1:0] val;
    logic          moved;
    logic          blocked;

    modport master (
        output restriction, dir_up, dir_down, dir_left, dir_right,
        input  pos_x, pos_y, val, moved, blocked
    );

    modport slave (
        input  restriction, dir_up, dir_down, dir_left, dir_right,
        output pos_x, pos_y, val, moved, blocked
    );
endinterface

// File: rtl/grid_cursor_gen.sv
// Keypad-grid cursor: edge-triggered moves with hold-to-repeat, border wrap/clamp,
// skip-over of digit cells forbidden by the restriction input, and moved/blocked pulses.
module grid_cursor_gen #(
    parameter int COLS          = 6,
    parameter int ROWS          = 4,
    parameter int DIG_COLS      = 4,
    parameter int DIG_ROWS_OK   = 2,
    parameter bit WRAP          = 1'b1,
    parameter bit SKIP          = 1'b1,
    parameter int HOLD_CYCLES   = 25_000_000,
    parameter int REPEAT_CYCLES = 5_000_000
) (
    input  logic         clk,
    input  logic         rst_n,
    grid_cursor_if.slave bus
);
    localparam int XW        = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int YW        = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int VW        = ((COLS * ROWS) > 1) ? $clog2(COLS * ROWS) : 1;
    localparam int MAX_STEPS = (COLS > ROWS) ? COLS : ROWS;
    localparam int CNT_SPAN  = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CW        = (CNT_SPAN > 2) ? $clog2(CNT_SPAN) : 1;

    localparam bit            REPEAT_EN    = (REPEAT_CYCLES > 0);
    localparam logic [CW-1:0] HOLD_LAST    = CW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
    localparam logic [CW-1:0] REP_LAST     = CW'(REPEAT_EN ? REPEAT_CYCLES - 1 : 0);
    localparam logic [XW-1:0] X_LAST       = XW'(COLS - 1);
    localparam logic [YW-1:0] Y_LAST       = YW'(ROWS - 1);
    localparam logic [XW-1:0] X_DIG        = XW'(DIG_COLS);
    localparam logic [YW-1:0] Y_OK         = YW'(DIG_ROWS_OK);
    localparam bit            ROWS_LIMITED = (DIG_ROWS_OK < ROWS);

    localparam logic [3:0] BTN_UP    = 4'b1000;
    localparam logic [3:0] BTN_DOWN  = 4'b0100;
    localparam logic [3:0] BTN_LEFT  = 4'b0010;
    localparam logic [3:0] BTN_RIGHT = 4'b0001;

    function automatic logic is_forbidden(input logic restr, input logic [XW-1:0] x,
                                          input logic [YW-1:0] y);
        return restr && (x < X_DIG) && ROWS_LIMITED && (y >= Y_OK);
    endfunction

    logic [3:0]    btn_s;
    logic [3:0]    btn_q_r;
    logic          single_s;
    logic          press_s;
    logic          repeat_s;
    logic          step_s;
    logic          snap_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_last_s;
    logic          first_r;
    logic [XW-1:0] pos_x_r;
    logic [YW-1:0] pos_y_r;
    logic [XW-1:0] tgt_x_s;
    logic [YW-1:0] tgt_y_s;
    logic          found_s;
    logic          search_done_s;
    logic          hit_edge_s;
    logic          moved_r;
    logic          blocked_r;
    logic [VW-1:0] val_s;

    assign btn_s      = {bus.dir_up, bus.dir_down, bus.dir_left, bus.dir_right};
    assign single_s   = (btn_s != 4'b0000) && ((btn_s & (btn_s - 4'b0001)) == 4'b0000);
    assign press_s    = single_s && ((btn_s & btn_q_r) == 4'b0000);
    assign cnt_last_s = first_r ? HOLD_LAST : REP_LAST;
    assign repeat_s   = REPEAT_EN && single_s && !press_s && (cnt_r == cnt_last_s);
    assign step_s     = press_s || repeat_s;
    assign snap_s     = is_forbidden(bus.restriction, pos_x_r, pos_y_r);

    // Walk from the cursor in the pressed direction until an allowed cell or a hard border
    always_comb begin
        tgt_x_s       = pos_x_r;
        tgt_y_s       = pos_y_r;
        found_s       = 1'b0;
        search_done_s = 1'b0;
        hit_edge_s    = 1'b0;
        for (int i = 0; i < MAX_STEPS; i++) begin
            if (!search_done_s) begin
                case (btn_s)
                    BTN_UP: begin
                        if (tgt_y_s != '0) tgt_y_s = tgt_y_s - YW'(1);
                        else if (WRAP)     tgt_y_s = Y_LAST;
                        else               hit_edge_s = 1'b1;
                    end
                    BTN_DOWN: begin
                        if (tgt_y_s != Y_LAST) tgt_y_s = tgt_y_s + YW'(1);
                        else if (WRAP)         tgt_y_s = '0;
                        else                   hit_edge_s = 1'b1;
                    end
                    BTN_LEFT: begin
                        if (tgt_x_s != '0) tgt_x_s = tgt_x_s - XW'(1);
                        else if (WRAP)     tgt_x_s = X_LAST;
                        else               hit_edge_s = 1'b1;
                    end
                    BTN_RIGHT: begin
                        if (tgt_x_s != X_LAST) tgt_x_s = tgt_x_s + XW'(1);
                        else if (WRAP)         tgt_x_s = '0;
                        else                   hit_edge_s = 1'b1;
                    end
                    default: hit_edge_s = 1'b1;
                endcase
                if (hit_edge_s) begin
                    search_done_s = 1'b1;
                end else if (!is_forbidden(bus.restriction, tgt_x_s, tgt_y_s)) begin
                    found_s       = 1'b1;
                    search_done_s = 1'b1;
                end else if (!SKIP) begin
                    search_done_s = 1'b1;
                end else begin
                    search_done_s = 1'b0;
                end
            end else begin
                search_done_s = 1'b1;
            end
        end
    end

    // Button history and hold-to-repeat counter; the first repeat waits HOLD, later ones REPEAT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q_r <= 4'b0000;
            cnt_r   <= '0;
            first_r <= 1'b1;
        end else begin
            btn_q_r <= btn_s;
            if (!single_s || press_s || !REPEAT_EN) begin
                cnt_r   <= '0;
                first_r <= 1'b1;
            end else if (repeat_s) begin
                cnt_r   <= '0;
                first_r <= 1'b0;
            end else begin
                cnt_r   <= cnt_r + CW'(1);
                first_r <= first_r;
            end
        end
    end

    // Cursor position and status pulses; snapping out of a forbidden cell wins over any move
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_x_r   <= '0;
            pos_y_r   <= '0;
            moved_r   <= 1'b0;
            blocked_r <= 1'b0;
        end else if (snap_s) begin
            pos_x_r   <= '0;
            pos_y_r   <= '0;
            moved_r   <= 1'b1;
            blocked_r <= 1'b0;
        end else if (step_s) begin
            if (found_s && ((tgt_x_s != pos_x_r) || (tgt_y_s != pos_y_r))) begin
                pos_x_r   <= tgt_x_s;
                pos_y_r   <= tgt_y_s;
                moved_r   <= 1'b1;
                blocked_r <= 1'b0;
            end else begin
                pos_x_r   <= pos_x_r;
                pos_y_r   <= pos_y_r;
                moved_r   <= 1'b0;
                blocked_r <= 1'b1;
            end
        end else begin
            pos_x_r   <= pos_x_r;
            pos_y_r   <= pos_y_r;
            moved_r   <= 1'b0;
            blocked_r <= 1'b0;
        end
    end

    // Key code: digits numbered row-major, commands column-major after all digits
    always_comb begin
        if (pos_x_r < X_DIG) begin
            val_s = VW'(pos_y_r) * VW'(DIG_COLS) + VW'(pos_x_r);
        end else begin
            val_s = VW'(DIG_COLS * ROWS) + VW'(pos_x_r - X_DIG) * VW'(ROWS) + VW'(pos_y_r);
        end
    end

    assign bus.pos_x   = pos_x_r;
    assign bus.pos_y   = pos_y_r;
    assign bus.val     = val_s;
    assign bus.moved   = moved_r;
    assign bus.blocked = blocked_r;
endmodule

// File: tb/tb_grid_cursor_gen.sv
// Bench for grid_cursor_gen: a wrap/skip instance and a clamp/refuse instance driven in lockstep.
module tb_grid_cursor_gen;
    localparam int COLS = 6;
    localparam int ROWS = 4;
    localparam int DIG_COLS = 4;
    localparam int DIG_ROWS_OK = 2;
    localparam int HOLD = 8;
    localparam int REP = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] btn;
    logic       restr;
    int         errors;
    int         checks;

    always #5 clk = ~clk;

    grid_cursor_if #(.COLS(COLS), .ROWS(ROWS)) ifa ();
    grid_cursor_if #(.COLS(COLS), .ROWS(ROWS)) ifb ();

    assign ifa.restriction = restr;
    assign ifa.dir_up = btn[3];
    assign ifa.dir_down = btn[2];
    assign ifa.dir_left = btn[1];
    assign ifa.dir_right = btn[0];
    assign ifb.restriction = restr;
    assign ifb.dir_up = btn[3];
    assign ifb.dir_down = btn[2];
    assign ifb.dir_left = btn[1];
    assign ifb.dir_right = btn[0];

    grid_cursor_gen #(.COLS(COLS), .ROWS(ROWS), .DIG_COLS(DIG_COLS), .DIG_ROWS_OK(DIG_ROWS_OK),
                      .WRAP(1'b1), .SKIP(1'b1), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));

    grid_cursor_gen #(.COLS(COLS), .ROWS(ROWS), .DIG_COLS(DIG_COLS), .DIG_ROWS_OK(DIG_ROWS_OK),
                      .WRAP(1'b0), .SKIP(1'b0), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    // reference model state, index 0 = wrap/skip, 1 = clamp/refuse
    int         mx[2];
    int         my[2];
    int         mheld[2];
    logic [3:0] mq[2];
    bit         em[2];
    bit         eb[2];
    bit         mwrap[2] = '{1'b1, 1'b0};
    bit         mskip[2] = '{1'b1, 1'b0};

    typedef struct {
        bit         r;
        logic [3:0] b;
        int         ex;
        int         ey;
        int         ev;
        bit         em;
    } vec_t;
    vec_t tbl[16];

    function automatic bit forb(input bit r, input int x, input int y);
        return r && (x < DIG_COLS) && (y >= DIG_ROWS_OK);
    endfunction

    function automatic int code(input int x, input int y);
        return (x < DIG_COLS) ? y * DIG_COLS + x : DIG_COLS * ROWS + (x - DIG_COLS) * ROWS + y;
    endfunction

    // n-th cell along the direction, wrapped by modulo or rejected past a border
    function automatic void search(input int x, input int y, input logic [3:0] b, input bit wrap,
                                   input bit skip, input bit r, output bit ok, output int nx,
                                   output int ny);
        int dx;
        int dy;
        int limit;
        dx = 0;
        dy = 0;
        limit = (COLS > ROWS) ? COLS : ROWS;
        ok = 1'b0;
        nx = x;
        ny = y;
        case (b)
            4'b1000: dy = -1;
            4'b0100: dy = 1;
            4'b0010: dx = -1;
            4'b0001: dx = 1;
            default: dx = 0;
        endcase
        for (int n = 1; n <= limit; n++) begin
            int tx;
            int ty;
            tx = x + n * dx;
            ty = y + n * dy;
            if (!wrap && (tx < 0 || tx >= COLS || ty < 0 || ty >= ROWS)) break;
            tx = ((tx % COLS) + COLS) % COLS;
            ty = ((ty % ROWS) + ROWS) % ROWS;
            if (!forb(r, tx, ty)) begin
                ok = 1'b1;
                nx = tx;
                ny = ty;
                break;
            end
            if (!skip) break;
        end
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mx[d] = 0;
            my[d] = 0;
            mheld[d] = 0;
            mq[d] = 4'b0000;
            em[d] = 1'b0;
            eb[d] = 1'b0;
        end
    endtask

    task automatic model_edge(input logic [3:0] b, input bit r);
        for (int d = 0; d < 2; d++) begin
            bit ev;
            bit ok;
            int nx;
            int ny;
            ev = 1'b0;
            em[d] = 1'b0;
            eb[d] = 1'b0;
            if ($countones(b) != 1) begin
                mheld[d] = 0;
            end else if ((b & mq[d]) == 4'b0000) begin
                ev = 1'b1;
                mheld[d] = 0;
            end else begin
                mheld[d]++;
                if (REP > 0 && (mheld[d] == HOLD || (mheld[d] > HOLD && (mheld[d] - HOLD) % REP == 0)))
                    ev = 1'b1;
            end
            if (forb(r, mx[d], my[d])) begin
                mx[d] = 0;
                my[d] = 0;
                em[d] = 1'b1;
            end else if (ev) begin
                search(mx[d], my[d], b, mwrap[d], mskip[d], r, ok, nx, ny);
                if (ok && (nx != mx[d] || ny != my[d])) begin
                    mx[d] = nx;
                    my[d] = ny;
                    em[d] = 1'b1;
                end else begin
                    eb[d] = 1'b1;
                end
            end
            mq[d] = b;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic chk_dut(input int d, input logic [31:0] px, input logic [31:0] py,
                           input logic [31:0] pv, input logic pm, input logic pb);
        chk($sformatf("dut%0d pos_x", d), px, 32'(mx[d]));
        chk($sformatf("dut%0d pos_y", d), py, 32'(my[d]));
        chk($sformatf("dut%0d val", d), pv, 32'(code(mx[d], my[d])));
        chk($sformatf("dut%0d moved", d), {31'd0, pm}, {31'd0, em[d]});
        chk($sformatf("dut%0d blocked", d), {31'd0, pb}, {31'd0, eb[d]});
    endtask

    task automatic check_all();
        chk_dut(0, 32'(ifa.pos_x), 32'(ifa.pos_y), 32'(ifa.val), ifa.moved, ifa.blocked);
        chk_dut(1, 32'(ifb.pos_x), 32'(ifb.pos_y), 32'(ifb.val), ifb.moved, ifb.blocked);
    endtask

    task automatic step(input logic [3:0] b, input bit r);
        btn = b;
        restr = r;
        @(posedge clk);
        model_edge(b, r);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        btn = 4'b0000;
        restr = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        int cnt_a;
        int cnt_any;
        logic [3:0] rb;
        bit rr;
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        btn = 4'b0000;
        restr = 1'b0;

        // right walk, then a plain down move and a restricted down move that wraps past two forbidden cells
        tbl[0]  = '{1'b0, 4'b0001, 1, 0, 1, 1'b1};
        tbl[1]  = '{1'b0, 4'b0000, 1, 0, 1, 1'b0};
        tbl[2]  = '{1'b0, 4'b0001, 2, 0, 2, 1'b1};
        tbl[3]  = '{1'b0, 4'b0000, 2, 0, 2, 1'b0};
        tbl[4]  = '{1'b0, 4'b0001, 3, 0, 3, 1'b1};
        tbl[5]  = '{1'b0, 4'b0000, 3, 0, 3, 1'b0};
        tbl[6]  = '{1'b0, 4'b0001, 4, 0, 16, 1'b1};
        tbl[7]  = '{1'b0, 4'b0000, 4, 0, 16, 1'b0};
        tbl[8]  = '{1'b0, 4'b0001, 5, 0, 20, 1'b1};
        tbl[9]  = '{1'b0, 4'b0000, 5, 0, 20, 1'b0};
        tbl[10] = '{1'b0, 4'b0001, 0, 0, 0, 1'b1};
        tbl[11] = '{1'b0, 4'b0000, 0, 0, 0, 1'b0};
        tbl[12] = '{1'b0, 4'b0100, 0, 1, 4, 1'b1};
        tbl[13] = '{1'b0, 4'b0000, 0, 1, 4, 1'b0};
        tbl[14] = '{1'b1, 4'b0100, 0, 0, 0, 1'b1};
        tbl[15] = '{1'b0, 4'b0000, 0, 0, 0, 1'b0};

        model_reset();
        #1;
        check_all();

        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].b, tbl[i].r);
            chk($sformatf("tbl%0d pos_x", i), 32'(ifa.pos_x), 32'(tbl[i].ex));
            chk($sformatf("tbl%0d pos_y", i), 32'(ifa.pos_y), 32'(tbl[i].ey));
            chk($sformatf("tbl%0d val", i), 32'(ifa.val), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d moved", i), {31'd0, ifa.moved}, {31'd0, tbl[i].em});
        end

        // refuse instance must block a down move into a forbidden cell
        do_reset();
        step(4'b0100, 1'b0);
        step(4'b0000, 1'b0);
        step(4'b0100, 1'b1);
        chk("noskip blocked", {31'd0, ifb.blocked}, 32'd1);
        chk("noskip pos_y", 32'(ifb.pos_y), 32'd1);
        chk("skip wrap pos_y", 32'(ifa.pos_y), 32'd0);
        step(4'b0000, 1'b0);
        chk("noskip blocked pulse", {31'd0, ifb.blocked}, 32'd0);

        // hold right: moves at k, k+8, k+11, k+14, k+17
        do_reset();
        cnt_a = 0;
        for (int j = 0; j < 20; j++) begin
            step(4'b0001, 1'b0);
            chk($sformatf("repeat edge%0d moved", j), {31'd0, ifa.moved},
                {31'd0, (j == 0 || j == 8 || j == 11 || j == 14 || j == 17)});
            cnt_a += int'(ifa.moved);
        end
        chk("repeat count", 32'(cnt_a), 32'd5);
        chk("repeat pos_x", 32'(ifa.pos_x), 32'd5);
        chk("repeat val", 32'(ifa.val), 32'd20);
        step(4'b0000, 1'b0);

        // two buttons, then the survivor is not a fresh press
        do_reset();
        cnt_any = 0;
        for (int j = 0; j < 10; j++) begin
            step(4'b1010, 1'b0);
            cnt_any += int'(ifa.moved) + int'(ifa.blocked) + int'(ifb.moved) + int'(ifb.blocked);
        end
        chk("two buttons events", 32'(cnt_any), 32'd0);
        for (int j = 0; j < 3; j++) begin
            step(4'b0010, 1'b0);
            cnt_any += int'(ifa.moved) + int'(ifb.moved);
        end
        chk("survivor no move", 32'(cnt_any), 32'd0);
        step(4'b0000, 1'b0);

        // clamp at the right border
        do_reset();
        for (int j = 0; j < 5; j++) begin
            step(4'b0001, 1'b0);
            step(4'b0000, 1'b0);
        end
        step(4'b0001, 1'b0);
        chk("clamp blocked", {31'd0, ifb.blocked}, 32'd1);
        chk("clamp pos_x", 32'(ifb.pos_x), 32'd5);
        chk("wrap pos_x", 32'(ifa.pos_x), 32'd0);
        step(4'b0000, 1'b0);

        // snap from (2,3) when restriction rises
        do_reset();
        for (int j = 0; j < 2; j++) begin
            step(4'b0001, 1'b0);
            step(4'b0000, 1'b0);
        end
        for (int j = 0; j < 3; j++) begin
            step(4'b0100, 1'b0);
            step(4'b0000, 1'b0);
        end
        step(4'b0000, 1'b1);
        chk("snap pos_x", 32'(ifa.pos_x), 32'd0);
        chk("snap pos_y", 32'(ifb.pos_y), 32'd0);
        chk("snap moved", {31'd0, ifb.moved}, 32'd1);
        step(4'b0000, 1'b0);

        // async reset mid-repeat, button still held across release
        do_reset();
        for (int j = 0; j < 10; j++) step(4'b0001, 1'b0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async pos_x", 32'(ifa.pos_x), 32'd0);
        chk("async moved", {31'd0, ifa.moved}, 32'd0);
        check_all();
        #3;
        rst_n = 1'b1;
        step(4'b0001, 1'b0);
        chk("post reset press", {31'd0, ifa.moved}, 32'd1);
        chk("post reset pos_x", 32'(ifa.pos_x), 32'd1);
        cnt_a = 0;
        for (int j = 0; j < 4; j++) begin
            step(4'b0001, 1'b0);
            cnt_a += int'(ifa.moved);
        end
        chk("post reset single move", 32'(cnt_a), 32'd0);
        step(4'b0000, 1'b0);

        // randomized holds against the model
        do_reset();
        rr = 1'b0;
        for (int seg = 0; seg < 50; seg++) begin
            int sel;
            int len;
            int bi;
            int bj;
            sel = int'($urandom_range(0, 9));
            bi = int'($urandom_range(0, 3));
            if (sel < 5) begin
                rb = 4'b0000;
            end else if (sel < 9) begin
                rb = 4'b0001 << bi;
            end else begin
                bj = (bi + 1 + int'($urandom_range(0, 2))) % 4;
                rb = (4'b0001 << bi) | (4'b0001 << bj);
            end
            if ($urandom_range(0, 5) == 0) rr = ~rr;
            len = int'($urandom_range(1, 14));
            for (int c = 0; c < len; c++) step(rb, rr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
